// File: rtl/laser_link_pkg.sv
// rtl/laser_link_pkg.sv - laser link framing constants and types shared by framer and deframer
package laser_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} deframe_state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/laser_frame_deframer_if.sv
// rtl/laser_frame_deframer_if.sv - receiver byte strobe and FTDI write queue handshake
interface laser_frame_deframer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wrq_full;
    logic       wrreq;
    logic [7:0] data_wr;

    modport slave (input rx_valid, rx_data, wrq_full, output wrreq, data_wr);
    modport master (output rx_valid, rx_data, wrq_full, input wrreq, data_wr);
endinterface

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - circular byte buffer with speculative write pointer, commit and rollback
module commit_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       commit,
    input  logic       rollback,
    input  logic       pop,
    output logic       full,
    output logic       avail,
    output logic [7:0] pop_data
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Rollback only rewinds the speculative pointer; rd_ptr and committed data are untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            if (rollback)  wr_ptr <= commit_ptr;
            else if (push) wr_ptr <= wr_ptr + 1'b1;
            if (commit)    commit_ptr <= wr_ptr;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign full     = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign avail    = rd_ptr != commit_ptr;
    assign pop_data = avail ? mem[rd_ptr[AW-1:0]] : 8'h00;
endmodule

// File: rtl/laser_frame_deframer.sv
// rtl/laser_frame_deframer.sv - laser link receive deframer; LASER_DEFRAME_STATS_EN enables frame counters
module laser_frame_deframer
    import laser_link_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    laser_frame_deframer_if.slave lnk,
    output logic                  frame_good,
    output logic                  frame_bad,
    output logic                  busy,
    output logic [15:0]           good_count,
    output logic [15:0]           bad_count
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    deframe_state_t state, state_nx;
    logic [CW-1:0]  cnt;
    logic [7:0]     chk;
    logic           ovf;
    logic [TW-1:0]  idle_cnt;
    logic           byte_in, len_ok, timeout_hit;
    logic           push, good_nx, bad_nx, fifo_full, fifo_avail;

    assign byte_in     = lnk.rx_valid && en;
    assign len_ok      = (lnk.rx_data != 8'h00) && (lnk.rx_data <= 8'(MAX_LEN));
    assign timeout_hit = (state != HUNT) && !byte_in && (idle_cnt == TW'(TIMEOUT - 1));
    assign busy        = state != HUNT;

    always_ff @(posedge clock) begin
        if (!reset) state <= HUNT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout_hit) begin
            state_nx = HUNT;
        end else if (byte_in) begin
            case (state)
                HUNT:    if (lnk.rx_data == SYNC_BYTE) state_nx = LEN;
                LEN:     state_nx = len_ok ? PAYLOAD : HUNT;
                PAYLOAD: if (cnt == CW'(1)) state_nx = CHECK;
                CHECK:   state_nx = HUNT;
                default: state_nx = HUNT;
            endcase
        end
    end

    always_comb begin
        push    = 1'b0;
        good_nx = 1'b0;
        bad_nx  = 1'b0;
        if (timeout_hit) begin
            bad_nx = 1'b1;
        end else if (byte_in) begin
            case (state)
                LEN:     bad_nx = !len_ok;
                PAYLOAD: push = !fifo_full;
                CHECK: begin
                    good_nx = (lnk.rx_data == chk) && !ovf;
                    bad_nx  = !((lnk.rx_data == chk) && !ovf);
                end
                default: ;
            endcase
        end
    end

    // Idle counter only runs inside a frame; accepted bytes restart it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt        <= '0;
            chk        <= 8'h00;
            ovf        <= 1'b0;
            idle_cnt   <= '0;
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            frame_good <= good_nx;
            frame_bad  <= bad_nx;
            if (byte_in || state == HUNT) idle_cnt <= '0;
            else                          idle_cnt <= idle_cnt + 1'b1;
            if (byte_in) begin
                case (state)
                    LEN: begin
                        cnt <= lnk.rx_data[CW-1:0];
                        chk <= lnk.rx_data;
                        ovf <= 1'b0;
                    end
                    PAYLOAD: begin
                        cnt <= cnt - CW'(1);
                        chk <= chk_update(chk, lnk.rx_data);
                        if (fifo_full) ovf <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (lnk.rx_data),
        .commit    (good_nx),
        .rollback  (bad_nx),
        .pop       (lnk.wrreq),
        .full      (fifo_full),
        .avail     (fifo_avail),
        .pop_data  (lnk.data_wr)
    );

    assign lnk.wrreq = fifo_avail && !lnk.wrq_full;

`ifdef LASER_DEFRAME_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            good_count <= 16'h0;
            bad_count  <= 16'h0;
        end else begin
            if (good_nx) good_count <= good_count + 16'd1;
            if (bad_nx)  bad_count  <= bad_count + 16'd1;
        end
    end
`else
    assign good_count = 16'h0;
    assign bad_count  = 16'h0;
`endif
endmodule
